// File: rtl/shift_reg_universal_seq_pkg.sv
// ----------------------------------------------------------------------------
// shift_reg_pkg
// Shared types for the command-driven universal shift register:
//   shift_op_t    - 3-bit operation code carried on cmd_op
//   shift_state_t - two-state sequencer encoding (IDLE / RUN)
//   is_single_cycle() - classifies ops that complete at the accept edge
// ----------------------------------------------------------------------------
package shift_reg_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ASR  = 3'b110,
        OP_CLR  = 3'b111
    } shift_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } shift_state_t;

    // NOP, LOAD and CLR update the register at the accept edge and ignore count.
    function automatic logic is_single_cycle(input shift_op_t op);
        logic res;
        case (op)
            OP_NOP, OP_LOAD, OP_CLR: res = 1'b1;
            default:                 res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shift_reg_universal_seq_step.sv
// ----------------------------------------------------------------------------
// shift_reg_step
// Purely combinational next-value function for one register update.
// Shift/rotate ops produce a single-bit step; LOAD/CLR/NOP produce the
// single-cycle result so the top needs only one next-value source.
// Ports:
//   op          - operation to apply
//   p           - current register value
//   s_left_din  - serial bit entering bit 0 on SHL
//   s_right_din - serial bit entering bit WIDTH-1 on SHR
//   cmd_data    - parallel value for LOAD
//   nxt         - resulting register value
// ----------------------------------------------------------------------------
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  shift_op_t          op,
    input  logic [WIDTH-1:0]   p,
    input  logic               s_left_din,
    input  logic               s_right_din,
    input  logic [WIDTH-1:0]   cmd_data,
    output logic [WIDTH-1:0]   nxt
);

    // One-step next-value selection by operation code.
    always_comb begin
        nxt = p;
        case (op)
            OP_NOP:  nxt = p;
            OP_LOAD: nxt = cmd_data;
            OP_SHR:  nxt = {s_right_din, p[WIDTH-1:1]};
            OP_SHL:  nxt = {p[WIDTH-2:0], s_left_din};
            OP_ROR:  nxt = {p[0], p[WIDTH-1:1]};
            OP_ROL:  nxt = {p[WIDTH-2:0], p[WIDTH-1]};
            OP_ASR:  nxt = {p[WIDTH-1], p[WIDTH-1:1]};
            OP_CLR:  nxt = {WIDTH{1'b0}};
            default: nxt = p;
        endcase
    end

endmodule

// File: rtl/shift_reg_universal_seq.sv
// ----------------------------------------------------------------------------
// shift_reg_universal_seq
// Command-driven universal shift register. A command accepted on the
// valid/ready port either updates the register at once (NOP/LOAD/CLR, or a
// shift/rotate with count 0) or runs count single-bit steps, one per clock,
// in the RUN state. done pulses for one cycle after completion; abort ends
// a running command early without done.
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready - command handshake; ready is high only in IDLE
//   cmd_op          - operation code (shift_op_t encoding)
//   cmd_count       - number of steps for shift/rotate ops
//   cmd_data        - LOAD value
//   abort           - stops a running command (ignored in IDLE)
//   s_left_din      - serial input for SHL
//   s_right_din     - serial input for SHR
//   p_dout          - register contents
//   s_left_dout     - p_dout[0]
//   s_right_dout    - p_dout[WIDTH-1]
//   busy            - high while in RUN
//   done            - one-cycle completion pulse
// ----------------------------------------------------------------------------
module shift_reg_universal_seq
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [CNT_W-1:0]   cmd_count,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic               abort,
    input  logic               s_left_din,
    input  logic               s_right_din,
    output logic [WIDTH-1:0]   p_dout,
    output logic               s_left_dout,
    output logic               s_right_dout,
    output logic               busy,
    output logic               done
);

    shift_state_t       state_r;
    shift_op_t          op_r;
    logic [CNT_W-1:0]   rem_r;
    logic [WIDTH-1:0]   p_r;
    logic               done_r;

    shift_op_t          cmd_op_s;
    shift_op_t          step_op_s;
    logic [WIDTH-1:0]   step_nxt_s;
    logic               cmd_ready_s;

    assign cmd_op_s    = shift_op_t'(cmd_op);
    assign cmd_ready_s = (state_r == ST_IDLE);

    // In IDLE the step unit serves the incoming command; in RUN the captured op.
    always_comb begin
        step_op_s = op_r;
        if (state_r == ST_IDLE) begin
            step_op_s = cmd_op_s;
        end else begin
            step_op_s = op_r;
        end
    end

    shift_reg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op          (step_op_s),
        .p           (p_r),
        .s_left_din  (s_left_din),
        .s_right_din (s_right_din),
        .cmd_data    (cmd_data),
        .nxt         (step_nxt_s)
    );

    // Sequencer, capture registers, data register and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_r    <= OP_NOP;
            rem_r   <= {CNT_W{1'b0}};
            p_r     <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (cmd_valid && cmd_ready_s) begin
                        if (is_single_cycle(cmd_op_s)) begin
                            p_r    <= step_nxt_s;
                            done_r <= 1'b1;
                        end else if (cmd_count == {CNT_W{1'b0}}) begin
                            // Zero-step shift/rotate completes at acceptance.
                            done_r <= 1'b1;
                        end else begin
                            // No step at the accept edge; steps start next edge.
                            op_r    <= cmd_op_s;
                            rem_r   <= cmd_count;
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // Steps already applied are kept; no done on abort.
                        rem_r   <= {CNT_W{1'b0}};
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end else begin
                        p_r   <= step_nxt_s;
                        rem_r <= rem_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        if (rem_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            done_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    rem_r   <= {CNT_W{1'b0}};
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_s;
    assign busy         = (state_r == ST_RUN);
    assign done         = done_r;
    assign p_dout       = p_r;
    assign s_left_dout  = p_r[0];
    assign s_right_dout = p_r[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_universal_seq.sv
// ----------------------------------------------------------------------------
// tb_shift_reg_universal_seq
// Directed plus randomized command sequences against a behavioural model
// that computes each step with plain integer arithmetic on an 8-bit value.
// ----------------------------------------------------------------------------
module tb_shift_reg_universal_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             abort;
    logic             s_left_din;
    logic             s_right_din;
    logic [WIDTH-1:0] p_dout;
    logic             s_left_dout;
    logic             s_right_dout;
    logic             busy;
    logic             done;

    int total;
    int bad;
    int mp;   // model register value, 0..255

    shift_reg_universal_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_count    (cmd_count),
        .cmd_data     (cmd_data),
        .abort        (abort),
        .s_left_din   (s_left_din),
        .s_right_din  (s_right_din),
        .p_dout       (p_dout),
        .s_left_dout  (s_left_dout),
        .s_right_dout (s_right_dout),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register and both serial outputs against the model.
    task automatic chk_p(input string tag);
        chk({tag, ".p"}, int'(p_dout), mp);
        chk({tag, ".sl"}, int'(s_left_dout), mp % 2);
        chk({tag, ".sr"}, int'(s_right_dout), mp / 128);
    endtask

    // Model of one step, written as arithmetic on an integer 0..255.
    function automatic int mstep(input int op, input int p, input int l, input int r);
        int res;
        case (op)
            2: res = p / 2 + r * 128;                   // SHR
            3: res = (p * 2 + l) % 256;                 // SHL
            4: res = p / 2 + (p % 2) * 128;             // ROR
            5: res = (p * 2) % 256 + p / 128;           // ROL
            6: res = p / 2 + (p >= 128 ? 128 : 0);      // ASR
            default: res = p;
        endcase
        return res;
    endfunction

    task automatic run_single(input int op, input int data);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_count = 5'($urandom);
        cmd_data  = 8'(data);
        abort     = 1'($urandom);   // abort has no effect in IDLE
        tick();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        cmd_data  = 8'($urandom);
        if (op == 1) mp = data % 256;
        else if (op == 7) mp = 0;
        chk_p("single");
        chk("single.done", int'(done), 1);
        chk("single.ready", int'(cmd_ready), 1);
        chk("single.busy", int'(busy), 0);
    endtask

    // Shift/rotate of n steps; serial bit for step k is pat[k-1]; abort_at=0 means none.
    task automatic run_shift(input int op, input int n, input int abort_at,
                             input logic [31:0] lpat, input logic [31:0] rpat);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_count = 5'(n);
        cmd_data  = 8'($urandom);
        abort     = 1'($urandom);   // ignored at the accept edge
        tick();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_count = 5'($urandom);
        cmd_data  = 8'($urandom);
        if (n == 0) begin
            chk_p("cnt0");
            chk("cnt0.done", int'(done), 1);
            chk("cnt0.ready", int'(cmd_ready), 1);
        end else begin
            chk_p("acc");
            chk("acc.busy", int'(busy), 1);
            chk("acc.ready", int'(cmd_ready), 0);
            chk("acc.done", int'(done), 0);
            for (int k = 1; k <= n; k++) begin
                s_left_din  = lpat[k-1];
                s_right_din = rpat[k-1];
                abort       = (k == abort_at);
                tick();
                if (k == abort_at) begin
                    abort = 1'b0;
                    chk_p("abort");
                    chk("abort.done", int'(done), 0);
                    chk("abort.ready", int'(cmd_ready), 1);
                    chk("abort.busy", int'(busy), 0);
                    break;
                end
                mp = mstep(op, mp, int'(lpat[k-1]), int'(rpat[k-1]));
                chk_p("step");
                chk("step.busy", int'(busy), (k == n) ? 0 : 1);
                chk("step.done", int'(done), (k == n) ? 1 : 0);
                chk("step.ready", int'(cmd_ready), (k == n) ? 1 : 0);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        mp    = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_count = 5'd0;
        cmd_data = 8'd0;
        abort = 1'b0;
        s_left_din = 1'b0;
        s_right_din = 1'b0;
        tick();
        tick();
        chk_p("rst");
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.ready", int'(cmd_ready), 1);
        rst_n = 1'b1;
        tick();

        // LOAD 0xA5
        run_single(1, 8'hA5);
        chk("load.lit", int'(p_dout), 32'h0000_00A5);
        tick();
        chk("load.done_clr", int'(done), 0);

        // ROL 3 from 0xA5 -> 0x4B, 0x96, 0x2D
        run_shift(5, 3, 0, 32'h0, 32'h0);
        chk("rol3.lit", int'(p_dout), 32'h0000_002D);

        // ASR 9 from 0x80 -> 0xFF
        run_single(1, 8'h80);
        run_shift(6, 9, 0, 32'h0, 32'h0);
        chk("asr9.lit", int'(p_dout), 32'h0000_00FF);

        // SHL 4 from 0x00 with serial bits 1,0,1,1 -> 0x0B
        run_single(1, 8'h00);
        run_shift(3, 4, 0, 32'h0000_000D, 32'h0);
        chk("shl4.lit", int'(p_dout), 32'h0000_000B);

        // SHR 6 from 0xF0, abort on the third step edge -> 0x3C
        run_single(1, 8'hF0);
        run_shift(2, 6, 3, 32'h0, 32'h0);
        chk("shr_abort.lit", int'(p_dout), 32'h0000_003C);
        tick();
        chk("shr_abort.nodone", int'(done), 0);

        // ROR count 0: done with value unchanged
        run_shift(4, 0, 0, 32'h0, 32'h0);
        chk("ror0.lit", int'(p_dout), 32'h0000_003C);

        // Back-to-back single-cycle commands, one per cycle
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_data  = 8'h5A;
        tick();
        chk("b2b1.p", int'(p_dout), 32'h0000_005A);
        chk("b2b1.ready", int'(cmd_ready), 1);
        cmd_op = 3'd7;
        tick();
        cmd_valid = 1'b0;
        mp = 0;
        chk_p("b2b2");
        chk("b2b2.done", int'(done), 1);

        // Reset asserted mid-RUN
        run_single(1, 8'hC3);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_count = 5'd10;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        mp = 0;
        chk_p("midrst");
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.ready", int'(cmd_ready), 1);
        chk("midrst.done", int'(done), 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("midrst.nodone", int'(done), 0);
        chk("midrst.idle", int'(busy), 0);

        // Randomized command stream
        for (int i = 0; i < 60; i++) begin
            int op;
            int n;
            int ab;
            op = int'($urandom_range(0, 7));
            if (op == 0 || op == 1 || op == 7) begin
                run_single(op, int'($urandom_range(0, 255)));
            end else begin
                n  = int'($urandom_range(0, 20));
                ab = ($urandom_range(0, 3) == 0 && n > 0) ? int'($urandom_range(1, n)) : 0;
                run_shift(op, n, ab, $urandom, $urandom);
            end
            if ($urandom_range(0, 1) == 1) begin
                tick();
                chk("rand.idle_done", int'(done), 0);
                chk_p("rand.idle");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
